int_flag_ctrl: RTL and testbench
================================

# int_flag_ctrl

Interrupt and flag controller sitting directly upstream of the shadow carry and zero flag registers. It holds the live C and Z flags and applies ALU and control-unit flag operations to them. It owns the interrupt-enable bit and drives the shadow registers' load strobe on interrupt entry. On return from interrupt it restores C and Z from the shadow outputs and re-arms or masks interrupts.

## Interface
Parameters:
- CNT_W, 8, width of saturating interrupt-entry counter INT_CNT

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- INTR  in  1  external interrupt request
- INST_BOUND  in  1  control unit at instruction boundary; interrupt may be taken
- C_SET, C_CLR, C_LD  in  1  carry set / clear / load-from-C_IN
- C_IN  in  1  ALU carry out
- Z_LD  in  1  load zero flag from Z_IN
- Z_IN  in  1  ALU zero result
- SEI, CLI  in  1  set / clear interrupt enable
- RETI  in  1  return-from-interrupt strobe
- RETI_IE  in  1  with RETI: 1 = RETIE (re-enable), 0 = RETID (stay masked)
- SHAD_C_Q, SHAD_Z_Q  in  1  shadow register outputs
- C_FLAG, Z_FLAG  out  1  live flags; also wired to shadow register IN
- SHAD_LD  out  1  shadow register load strobe
- INT_ACK  out  1  one-cycle pulse; control unit vectors to ISR
- IE  out  1  interrupt enable
- IN_ISR  out  1  high while servicing an interrupt
- INT_CNT  out  CNT_W  interrupts taken, saturating

## Operation
- FSM states: IDLE, SAVE, ISR.
- Request signal REQ: the pending latch or the INTR level, depending on configuration.
- IDLE to SAVE: when IE && REQ && INST_BOUND.
- SAVE lasts exactly one cycle and then moves to ISR.
  - SHAD_LD=1 and INT_ACK=1 are combinational from the state.
  - The shadow registers capture the current C_FLAG/Z_FLAG at the closing edge.
  - All flag ops are ignored so the saved values are frozen.
  - IE is cleared, the pending latch is cleared, and INT_CNT increments (holds at all-ones).
- ISR to IDLE: on RETI.
  - C_FLAG<=SHAD_C_Q, Z_FLAG<=SHAD_Z_Q, IE<=RETI_IE.
  - Restore overrides any flag op in the same cycle.
- RETI in IDLE or SAVE: no effect.
- No nesting: while in SAVE or ISR, requests latch into pending but are not acknowledged until the FSM is back in IDLE.
- Carry priority per cycle: C_CLR > C_SET > C_LD > hold.
- Z_LD loads Z_IN; otherwise Z holds.
- IE updates:
  - Entering SAVE clears IE.
  - Otherwise RETI-restore sets IE to RETI_IE.
  - Otherwise CLI clears IE.
  - Otherwise SEI sets IE.
  - CLI has priority over SEI.
- IN_ISR = state is SAVE or ISR.

## Timing
- Reset (RST_N low, async): state IDLE; C_FLAG, Z_FLAG, IE, pending, INT_CNT all 0; SHAD_LD, INT_ACK, IN_ISR 0.
- Reset mid-ISR discards the ISR context; no restore is performed.
- Latency, qualifying cycle to acknowledge: INT_ACK is high in the cycle immediately after the edge at which IE&&REQ&&INST_BOUND was sampled.
- Latency, RETI to restore: restored flags are visible one cycle after the RETI edge.
- Same-cycle SEI and request: the SEI takes effect at the edge, so the interrupt is taken no earlier than the following qualifying cycle.
- Same-cycle SEI and entry into SAVE: the clear wins; IE=0.
- INTR arriving while in ISR is serviced after RETIE, on the first qualifying IDLE cycle.

## Configuration
- INT_EDGE_DETECT_EN defined:
  - INTR is registered, reset value 0.
  - A rising edge sets a sticky pending latch, which is cleared only on entry to SAVE.
  - REQ = pending.
- INT_EDGE_DETECT_EN undefined:
  - No pending latch; REQ = INTR level.
  - A request that drops before qualifying is lost.
  - A request held high through RETIE re-enters immediately.

## Test plan
- Reset, then C_LD=1 with C_IN=1, then Z_LD=1 with Z_IN=1 -> C_FLAG=1, Z_FLAG=1, IE=0, INT_CNT=0.
- Flags C=1, Z=0; SEI; INTR pulse; INST_BOUND=1 -> SAVE for one cycle with SHAD_LD=1 and INT_ACK=1; then IE=0, IN_ISR=1, INT_CNT=1.
- In ISR, force C=0 and Z=1; drive SHAD_C_Q=1, SHAD_Z_Q=0; RETI with RETI_IE=1 -> next cycle C_FLAG=1, Z_FLAG=0, IE=1, IN_ISR=0.
- RETI with RETI_IE=0 -> IE=0. A subsequent INTR is not acknowledged until SEI, and is then acknowledged at the first INST_BOUND.
- C_SET, C_CLR and C_LD asserted together with C_IN=1 -> C_FLAG=0. Same check in SAVE -> C_FLAG unchanged.
- With the macro defined: INTR pulses during ISR -> exactly one INT_ACK after RETIE. Also run 256 interrupt entries with CNT_W=8 -> INT_CNT saturates at 255.

Source files
------------

// File: rtl/int_flag_ctrl.sv
// rtl/int_flag_ctrl.sv - interrupt entry/return sequencer owning the live C/Z flags and IE
//
// Holds the live carry and zero flags, applies ALU/control-unit flag ops,
// owns the interrupt-enable bit, pulses the shadow-register load on entry
// and restores C/Z from the shadow registers on return.
//
// Optional feature macro: INT_EDGE_DETECT_EN
//   defined   : INTR is edge-detected into a sticky pending latch (REQ = pending)
//   undefined : REQ is the raw INTR level
//
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   INTR, INST_BOUND       interrupt request, instruction-boundary qualifier
//   C_SET, C_CLR, C_LD     carry ops (priority CLR > SET > LD), C_IN load data
//   Z_LD, Z_IN             zero-flag load and data
//   SEI, CLI               set / clear interrupt enable (CLI wins)
//   RETI, RETI_IE          return strobe, IE value to restore
//   SHAD_C_Q, SHAD_Z_Q     shadow register outputs used on return
//   C_FLAG, Z_FLAG         live flags (also feed the shadow register inputs)
//   SHAD_LD, INT_ACK       asserted for the single SAVE cycle
//   IE, IN_ISR             interrupt enable, servicing indicator
//   INT_CNT                saturating count of interrupts taken
module int_flag_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INTR,
  input  logic             INST_BOUND,
  input  logic             C_SET,
  input  logic             C_CLR,
  input  logic             C_LD,
  input  logic             C_IN,
  input  logic             Z_LD,
  input  logic             Z_IN,
  input  logic             SEI,
  input  logic             CLI,
  input  logic             RETI,
  input  logic             RETI_IE,
  input  logic             SHAD_C_Q,
  input  logic             SHAD_Z_Q,
  output logic             C_FLAG,
  output logic             Z_FLAG,
  output logic             SHAD_LD,
  output logic             INT_ACK,
  output logic             IE,
  output logic             IN_ISR,
  output logic [CNT_W-1:0] INT_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             ie_q, ie_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req;
  logic take;
  logic restore;

  assign take    = (state_q == ST_IDLE) && ie_q && req && INST_BOUND;
  assign restore = (state_q == ST_ISR) && RETI;

`ifdef INT_EDGE_DETECT_EN
  logic intr_q;
  logic pend_q, pend_d;

  // A rising edge seen in the same cycle as entry keeps the latch set so
  // that the newer request is not lost behind the one being taken.
  always_comb begin
    pend_d = (pend_q && !take) || (INTR && !intr_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      intr_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      intr_q <= INTR;
      pend_q <= pend_d;
    end
  end

  assign req = pend_q;
`else
  assign req = INTR;
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    z_d     = z_q;
    ie_d    = ie_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: if (take) state_d = ST_SAVE;
      ST_SAVE: state_d = ST_ISR;
      ST_ISR:  if (RETI) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flags are frozen during SAVE so the shadow captures a stable value.
    if (state_q == ST_SAVE) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (restore) begin
      c_d = SHAD_C_Q;
      z_d = SHAD_Z_Q;
    end else begin
      if (C_CLR)      c_d = 1'b0;
      else if (C_SET) c_d = 1'b1;
      else if (C_LD)  c_d = C_IN;
      if (Z_LD)       z_d = Z_IN;
    end

    // IE is forced low from the entry edge through the end of SAVE.
    if (take || (state_q == ST_SAVE)) ie_d = 1'b0;
    else if (restore)                 ie_d = RETI_IE;
    else if (CLI)                     ie_d = 1'b0;
    else if (SEI)                     ie_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ie_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ie_q    <= ie_d;
      cnt_q   <= cnt_d;
    end
  end

  assign C_FLAG  = c_q;
  assign Z_FLAG  = z_q;
  assign IE      = ie_q;
  assign INT_CNT = cnt_q;
  assign SHAD_LD = (state_q == ST_SAVE);
  assign INT_ACK = (state_q == ST_SAVE);
  assign IN_ISR  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_int_flag_ctrl.sv
// tb/tb_int_flag_ctrl.sv - randomized and directed checks of int_flag_ctrl against a behavioural model
module tb_int_flag_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
`ifdef INT_EDGE_DETECT_EN
  localparam int EDGE_MODE = 1;
`else
  localparam int EDGE_MODE = 0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic INTR = 0, INST_BOUND = 0;
  logic C_SET = 0, C_CLR = 0, C_LD = 0, C_IN = 0;
  logic Z_LD = 0, Z_IN = 0, SEI = 0, CLI = 0;
  logic RETI = 0, RETI_IE = 0, SHAD_C_Q = 0, SHAD_Z_Q = 0;
  logic C_FLAG, Z_FLAG, SHAD_LD, INT_ACK, IE, IN_ISR;
  logic [CNT_W-1:0] INT_CNT;

  int n_chk = 0;
  int n_err = 0;

  int_flag_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .INST_BOUND(INST_BOUND),
    .C_SET(C_SET), .C_CLR(C_CLR), .C_LD(C_LD), .C_IN(C_IN),
    .Z_LD(Z_LD), .Z_IN(Z_IN), .SEI(SEI), .CLI(CLI),
    .RETI(RETI), .RETI_IE(RETI_IE), .SHAD_C_Q(SHAD_C_Q), .SHAD_Z_Q(SHAD_Z_Q),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .SHAD_LD(SHAD_LD), .INT_ACK(INT_ACK),
    .IE(IE), .IN_ISR(IN_ISR), .INT_CNT(INT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: an interrupt "busy" window that opens on entry, whose
  // first cycle is the save cycle, and which closes on a return.
  bit m_c, m_z, m_ie, m_pend, m_intr_prev, m_busy, m_saving;
  int m_cnt;

  task automatic model_reset();
    m_c = 0; m_z = 0; m_ie = 0; m_pend = 0; m_intr_prev = 0;
    m_busy = 0; m_saving = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit req, take, ret;
    req  = EDGE_MODE ? m_pend : INTR;
    take = !m_busy && m_ie && req && INST_BOUND;
    ret  = m_busy && !m_saving && RETI;
    if (m_saving) begin
      m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
    end else if (ret) begin
      m_c = SHAD_C_Q; m_z = SHAD_Z_Q;
    end else begin
      if (C_CLR) m_c = 0; else if (C_SET) m_c = 1; else if (C_LD) m_c = C_IN;
      if (Z_LD) m_z = Z_IN;
    end
    if (take || m_saving) m_ie = 0;
    else if (ret)         m_ie = RETI_IE;
    else if (CLI)         m_ie = 0;
    else if (SEI)         m_ie = 1;
    m_pend = (m_pend && !take) || (INTR && !m_intr_prev);
    m_intr_prev = INTR;
    if (take) begin m_busy = 1; m_saving = 1; end
    else if (m_saving) m_saving = 0;
    else if (ret) m_busy = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("c_flag",  C_FLAG,  m_c);
    chk("z_flag",  Z_FLAG,  m_z);
    chk("ie",      IE,      m_ie);
    chk("shad_ld", SHAD_LD, m_saving);
    chk("int_ack", INT_ACK, m_saving);
    chk("in_isr",  IN_ISR,  m_busy);
    chk("int_cnt", INT_CNT, m_cnt);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle_inputs();
    INTR = 0; INST_BOUND = 0; C_SET = 0; C_CLR = 0; C_LD = 0; C_IN = 0;
    Z_LD = 0; Z_IN = 0; SEI = 0; CLI = 0; RETI = 0; RETI_IE = 0;
    SHAD_C_Q = 0; SHAD_Z_Q = 0;
  endtask

  // Returns at the falling edge inside the save cycle.
  task automatic take_int();
    bit got;
    got = 0;
    if (!m_ie) begin SEI = 1; tick(); SEI = 0; end
    INTR = 1; INST_BOUND = 1;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (INT_ACK) got = 1;
    end
    chk("ack_seen", got, 1);
    INTR = 0; INST_BOUND = 0;
  endtask

  task automatic reti(input bit ie);
    RETI = 1; RETI_IE = ie;
    tick();
    RETI = 0; RETI_IE = 0;
  endtask

  initial begin
    int acks;
    bit got;
    idle_inputs();
    model_reset();
    RST_N = 0;
    repeat (2) @(negedge CLK);
    compare_all();
    RST_N = 1;

    // Load flags from the ALU path.
    C_LD = 1; C_IN = 1; tick(); C_LD = 0; C_IN = 0;
    Z_LD = 1; Z_IN = 1; tick(); Z_LD = 0; Z_IN = 0;
    chk("tp1_c", C_FLAG, 1); chk("tp1_z", Z_FLAG, 1);
    chk("tp1_ie", IE, 0); chk("tp1_cnt", INT_CNT, 0);

    // Entry with C=1 Z=0; flag ops during SAVE must be ignored.
    Z_LD = 1; Z_IN = 0; tick(); Z_LD = 0;
    take_int();
    chk("tp2_shad_ld", SHAD_LD, 1);
    C_SET = 1; C_CLR = 1; C_LD = 1; C_IN = 1; Z_LD = 1; Z_IN = 1;
    tick();
    C_SET = 0; C_CLR = 0; C_LD = 0; C_IN = 0; Z_LD = 0; Z_IN = 0;
    chk("tp2_c_frozen", C_FLAG, 1); chk("tp2_z_frozen", Z_FLAG, 0);
    chk("tp2_ie", IE, 0); chk("tp2_in_isr", IN_ISR, 1); chk("tp2_cnt", INT_CNT, 1);

    // Modify flags in the ISR, then RETIE restores over a concurrent op.
    C_CLR = 1; Z_LD = 1; Z_IN = 1; tick(); Z_LD = 0; Z_IN = 0;
    chk("tp3_c_isr", C_FLAG, 0); chk("tp3_z_isr", Z_FLAG, 1);
    SHAD_C_Q = 1; SHAD_Z_Q = 0;
    reti(1);
    C_CLR = 0; SHAD_C_Q = 0;
    chk("tp3_c_rest", C_FLAG, 1); chk("tp3_z_rest", Z_FLAG, 0);
    chk("tp3_ie", IE, 1); chk("tp3_in_isr", IN_ISR, 0);

    // RETID keeps interrupts masked until SEI.
    take_int(); tick();
    reti(0);
    chk("tp4_ie", IE, 0);
    INTR = 1; INST_BOUND = 1; acks = 0;
    repeat (4) begin tick(); acks += INT_ACK; end
    chk("tp4_masked_acks", acks, 0);
    SEI = 1; tick(); SEI = 0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin tick(); if (INT_ACK) got = 1; end
    chk("tp4_ack_after_sei", got, 1);
    INTR = 0; INST_BOUND = 0; tick();
    reti(1);

    // All carry ops together in IDLE: clear wins.
    C_SET = 1; C_CLR = 1; C_LD = 1; C_IN = 1; tick();
    C_SET = 0; C_CLR = 0; C_LD = 0; C_IN = 0;
    chk("tp5_c_prio", C_FLAG, 0);

    // Requests pulsed during ISR: one deferred ack only with edge detection.
    take_int(); tick();
    repeat (3) begin INTR = 1; tick(); INTR = 0; tick(); end
    INST_BOUND = 1;
    reti(1);
    acks = 0;
    repeat (8) begin tick(); acks += INT_ACK; end
    chk("tp6_deferred_acks", acks, EDGE_MODE ? 1 : 0);
    INST_BOUND = 0; tick();
    reti(1);

    // Counter saturation.
    repeat (CNT_TOP + 5) begin take_int(); tick(); reti(1); end
    chk("tp7_cnt_sat", INT_CNT, CNT_TOP);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) INTR = ~INTR;
      INST_BOUND = $urandom_range(0, 1);
      C_SET = ($urandom_range(0, 4) == 0); C_CLR = ($urandom_range(0, 4) == 0);
      C_LD = ($urandom_range(0, 2) == 0); C_IN = $urandom_range(0, 1);
      Z_LD = ($urandom_range(0, 2) == 0); Z_IN = $urandom_range(0, 1);
      SEI = ($urandom_range(0, 5) == 0); CLI = ($urandom_range(0, 11) == 0);
      RETI = ($urandom_range(0, 5) == 0); RETI_IE = $urandom_range(0, 1);
      SHAD_C_Q = $urandom_range(0, 1); SHAD_Z_Q = $urandom_range(0, 1);
      if (cyc == 1500) begin
        #2 RST_N = 0;
        #1 model_reset();
        compare_all();
        @(negedge CLK);
        RST_N = 1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
